// File: rtl/sc_pkg.sv
// ---------------------------------------------------------------------------
// sc_pkg
// Shared definitions for the stochastic-number-generator stream scheduler:
//   SC_WIDTH_DEFAULT  default operand / LFSR width
//   sng_state_e       scheduler FSM state encoding
//   lfsr_taps()       maximal-length Fibonacci tap mask for widths 4..16.
//                     Bit k-1 set means polynomial term x^k participates.
// ---------------------------------------------------------------------------
package sc_pkg;

    localparam int SC_WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } sng_state_e;

    function automatic logic [15:0] lfsr_taps(input int width);
        logic [15:0] taps;
        case (width)
            4:       taps = 16'h000C;  // x^4+x^3+1
            5:       taps = 16'h0014;  // x^5+x^3+1
            6:       taps = 16'h0030;  // x^6+x^5+1
            7:       taps = 16'h0060;  // x^7+x^6+1
            8:       taps = 16'h00B8;  // x^8+x^6+x^5+x^4+1
            9:       taps = 16'h0110;  // x^9+x^5+1
            10:      taps = 16'h0240;  // x^10+x^7+1
            11:      taps = 16'h0500;  // x^11+x^9+1
            12:      taps = 16'h0E08;  // x^12+x^11+x^10+x^4+1
            13:      taps = 16'h1C80;  // x^13+x^12+x^11+x^8+1
            14:      taps = 16'h3802;  // x^14+x^13+x^12+x^2+1
            15:      taps = 16'h6000;  // x^15+x^14+1
            16:      taps = 16'hD008;  // x^16+x^15+x^13+x^4+1
            default: taps = 16'h00B8;
        endcase
        return taps;
    endfunction

endpackage

// File: rtl/sc_lfsr.sv
// ---------------------------------------------------------------------------
// sc_lfsr
// Fibonacci LFSR used as the random source of the stochastic comparator.
// Shifts left; the XOR of the tapped bits enters at bit 0.
// Ports:
//   clk    in   clock
//   rst_n  in   asynchronous active-low reset (value returns to SEED)
//   load   in   reload SEED (has priority over step)
//   step   in   advance one state
//   value  out  current LFSR state
// ---------------------------------------------------------------------------
module sc_lfsr
    import sc_pkg::*;
#(
    parameter int               WIDTH = SC_WIDTH_DEFAULT,
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(8'hB5)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             step,
    output logic [WIDTH-1:0] value
);

    localparam logic [WIDTH-1:0] TAPS = WIDTH'(lfsr_taps(WIDTH));

    logic fb;
    assign fb = ^(value & TAPS);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= SEED;
        end else if (load) begin
            value <= SEED;
        end else if (step) begin
            value <= {value[WIDTH-2:0], fb};
        end
    end

    // An all-zero state is a lock-up state of an XOR LFSR.
    seed_nonzero: assert property (@(posedge clk) SEED != '0);
    never_zero:   assert property (@(posedge clk) disable iff (!rst_n) value != '0);

endmodule

// File: rtl/sng_stream_scheduler.sv
// ---------------------------------------------------------------------------
// sng_stream_scheduler
// Time-shares one external registered comparator (cmp_st = bin2 < bin1,
// one-cycle latency) among NUM_REQ requesters. A round-robin winner has its
// operand latched, and a STREAM_LEN-bit stochastic stream is produced by
// comparing that operand against an LFSR reseeded at every stream start.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   req           per-requester request, held until stream_done or abort
//   bin_in        operands, requester i at [i*WIDTH +: WIDTH]
//   grant         one-hot owner while streaming, 0 otherwise
//   cmp_bin1      comparator operand: latched requester value
//   cmp_bin2      comparator operand: current LFSR value
//   cmp_st        comparator result (registered)
//   bit_out       stochastic bit (cmp_st forwarded)
//   bit_valid     bit_out belongs to the owner's stream
//   bit_owner     owner index for bit_out
//   stream_done   one-cycle pulse on the owner's bit with its last bit
// ---------------------------------------------------------------------------
module sng_stream_scheduler
    import sc_pkg::*;
#(
    parameter int               NUM_REQ    = 4,
    parameter int               WIDTH      = SC_WIDTH_DEFAULT,
    parameter int               STREAM_LEN = (1 << WIDTH) - 1,
    parameter logic [WIDTH-1:0] LFSR_SEED  = WIDTH'(8'hB5)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*WIDTH-1:0]   bin_in,
    output logic [NUM_REQ-1:0]         grant,
    output logic [WIDTH-1:0]           cmp_bin1,
    output logic [WIDTH-1:0]           cmp_bin2,
    input  logic                       cmp_st,
    output logic                       bit_out,
    output logic                       bit_valid,
    output logic [$clog2(NUM_REQ)-1:0] bit_owner,
    output logic [NUM_REQ-1:0]         stream_done
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(STREAM_LEN + 1);

    sng_state_e       state, state_nxt;
    logic [WIDTH-1:0] operand;
    logic [IDX_W-1:0] owner, rr_ptr, pick_idx, next_ptr;
    logic [WIDTH-1:0] pick_opnd;
    logic             pick_vld;
    logic [CNT_W-1:0] cnt;
    logic             issued;
    logic             owner_req, last_cmp, lfsr_load, lfsr_step;
    logic [WIDTH-1:0] lfsr_value;

    assign owner_req = req[owner];
    assign last_cmp  = (cnt == CNT_W'(STREAM_LEN - 1));
    assign next_ptr  = (owner == IDX_W'(NUM_REQ - 1)) ? '0 : owner + IDX_W'(1);
    assign lfsr_load = (state == IDLE) && pick_vld;
    assign lfsr_step = (state == RUN);

    // Round-robin pick: scanning from the far end down means the last hit,
    // which wins, is the first set request at or after rr_ptr.
    always_comb begin
        int idx;
        idx       = 0;
        pick_vld  = 1'b0;
        pick_idx  = '0;
        pick_opnd = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (req[IDX_W'(idx)]) begin
                pick_vld = 1'b1;
                pick_idx = IDX_W'(idx);
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_idx == IDX_W'(i)) pick_opnd = bin_in[i*WIDTH +: WIDTH];
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // FSM next state; a dropped owner request aborts, even on the last compare
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (pick_vld) state_nxt = RUN;
            RUN: begin
                if (!owner_req)    state_nxt = IDLE;
                else if (last_cmp) state_nxt = DRAIN;
            end
            DRAIN:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        grant       = '0;
        stream_done = '0;
        if (state == RUN)   grant[owner]       = 1'b1;
        if (state == DRAIN) stream_done[owner] = 1'b1;
    end

    // Stream bookkeeping. issued marks that a compare started this cycle and
    // belongs to a live stream; the comparator answers one cycle later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            operand <= '0;
            owner   <= '0;
            rr_ptr  <= '0;
            cnt     <= '0;
            issued  <= 1'b0;
        end else begin
            issued <= (state == RUN) && owner_req;
            unique case (state)
                IDLE: begin
                    if (pick_vld) begin
                        owner   <= pick_idx;
                        operand <= pick_opnd;
                        cnt     <= '0;
                    end
                end
                RUN: begin
                    cnt <= cnt + CNT_W'(1);
                    if (!owner_req) rr_ptr <= next_ptr;
                end
                DRAIN:   rr_ptr <= next_ptr;
                default: ;
            endcase
        end
    end

    sc_lfsr #(
        .WIDTH (WIDTH),
        .SEED  (LFSR_SEED)
    ) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (lfsr_load),
        .step  (lfsr_step),
        .value (lfsr_value)
    );

    assign cmp_bin1  = operand;
    assign cmp_bin2  = lfsr_value;
    assign bit_out   = cmp_st;
    assign bit_valid = issued;
    assign bit_owner = owner;

endmodule

// File: tb/tb_sng_stream_scheduler.sv
// ---------------------------------------------------------------------------
// tb_sng_stream_scheduler
// Directed bench for sng_stream_scheduler with its external registered
// comparator. Streams are checked for length, ones count, done pulses,
// ownership, round-robin order, abort, and asynchronous reset behaviour.
// ---------------------------------------------------------------------------
module tb_sng_stream_scheduler;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [31:0] bin_in;
    logic [3:0]  grant;
    logic [7:0]  cmp_bin1;
    logic [7:0]  cmp_bin2;
    logic        cmp_st;
    logic        bit_out;
    logic        bit_valid;
    logic [1:0]  bit_owner;
    logic [3:0]  stream_done;

    int n_tests = 0;
    int n_fail  = 0;

    sng_stream_scheduler dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .bin_in      (bin_in),
        .grant       (grant),
        .cmp_bin1    (cmp_bin1),
        .cmp_bin2    (cmp_bin2),
        .cmp_st      (cmp_st),
        .bit_out     (bit_out),
        .bit_valid   (bit_valid),
        .bit_owner   (bit_owner),
        .stream_done (stream_done)
    );

    // Registered comparator: 1 iff bin2 < bin1, one cycle of latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cmp_st <= 1'b0;
        else        cmp_st <= (cmp_bin2 < cmp_bin1);
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_grant(output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (grant == 4'b0 && cycles < 20);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_grant"}, 32'(grant), 32'h0);
        check({tag, "_bin1"}, 32'(cmp_bin1), 32'h0);
        check({tag, "_bin2"}, 32'(cmp_bin2), 32'hB5);
        check({tag, "_valid"}, 32'(bit_valid), 32'h0);
        check({tag, "_owner"}, 32'(bit_owner), 32'h0);
        check({tag, "_done"}, 32'(stream_done), 32'h0);
    endtask

    // One full stream from requester who; expects 255 bits with exp_ones ones.
    task automatic run_one(input int who, input logic [7:0] opnd, input int exp_ones, input bit toggle);
        int         ones, vcnt, dcnt, bad, c, tail, t;
        logic [7:0] b2 [3];
        ones = 0; vcnt = 0; dcnt = 0; bad = 0; c = 0; tail = -1;
        bin_in[who*8 +: 8] = opnd;
        req[who] = 1'b1;
        wait_grant(t);
        check("run_grant", 32'(grant), 32'(1 << who));
        check("run_bin1", 32'(cmp_bin1), 32'(opnd));
        b2[0] = cmp_bin2;
        b2[1] = '0;
        b2[2] = '0;
        while (c < 300 && tail != 0) begin
            if (toggle) bin_in[who*8 +: 8] = bin_in[who*8 +: 8] ^ 8'hFF;
            @(negedge clk);
            c++;
            if (tail > 0) tail--;
            if (c == 1) b2[1] = cmp_bin2;
            if (c == 2) b2[2] = cmp_bin2;
            if (!$onehot0(grant)) bad++;
            if (bit_valid) begin
                vcnt++;
                ones += int'(bit_out);
                if (int'(bit_owner) != who) bad++;
            end
            if (stream_done != 4'b0) begin
                dcnt++;
                if (stream_done != 4'(1 << who)) bad++;
                req[who] = 1'b0;
                if (tail < 0) tail = 4;
            end
        end
        req[who] = 1'b0;
        check("run_lfsr0", 32'(b2[0]), 32'hB5);
        check("run_lfsr1", 32'(b2[1]), 32'h6B);
        check("run_lfsr2", 32'(b2[2]), 32'hD6);
        check("run_bits", 32'(vcnt), 32'd255);
        check("run_ones", 32'(ones), 32'(exp_ones));
        check("run_done", 32'(dcnt), 32'd1);
        check("run_owner_bad", 32'(bad), 32'd0);
    endtask

    initial begin
        int         t, vcnt, dcnt, bad, cur, n1, n2, diff;
        logic [0:0] cap1 [100];
        logic [0:0] cap2 [100];

        rst_n  = 1'b1;
        req    = 4'b0;
        bin_in = 32'h0;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_values("rst");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_grant", 32'(grant), 32'h0);

        // Single streams: ones = count of nonzero LFSR states below operand.
        run_one(0, 8'd128, 127, 1'b0);
        run_one(1, 8'd0,   0,   1'b0);
        run_one(2, 8'd255, 254, 1'b0);
        run_one(3, 8'd1,   0,   1'b0);

        // All requesting: rr_ptr is back at 0 after requester 3.
        bin_in = 32'h40_80_20_10;
        req    = 4'b1111;
        cur    = -1;
        bad    = 0;
        dcnt   = 0;
        for (int g = 0; g < 5; g++) begin
            t = 0;
            do begin
                @(negedge clk);
                t++;
                if (bit_valid && int'(bit_owner) != cur) bad++;
                if (!$onehot0(grant)) bad++;
                if (stream_done != 4'b0) dcnt++;
            end while (grant == 4'b0 && t < 20);
            check("rr_grant", 32'(grant), 32'(1 << (g % 4)));
            cur = g % 4;
            if (g == 4) begin
                req = 4'b0;
            end else begin
                t = 0;
                do begin
                    @(negedge clk);
                    t++;
                    if (bit_valid && int'(bit_owner) != cur) bad++;
                    if (!$onehot0(grant)) bad++;
                    if (stream_done != 4'b0) dcnt++;
                end while (grant != 4'b0 && t < 300);
            end
        end
        check("rr_owner_bad", 32'(bad), 32'd0);
        check("rr_dones", 32'(dcnt), 32'd4);
        repeat (3) @(negedge clk);
        check("rr_abort_idle", 32'(grant), 32'h0);

        // Abort: rr_ptr=1 after requester 0 was aborted, so 2 wins over 3.
        req = 4'b1100;
        wait_grant(t);
        check("abort_grant", 32'(grant), 32'b0100);
        vcnt = 0;
        dcnt = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (bit_valid) vcnt++;
            if (stream_done != 4'b0) dcnt++;
        end
        req[2] = 1'b0;
        @(negedge clk);
        if (bit_valid) vcnt++;
        if (stream_done != 4'b0) dcnt++;
        check("abort_grant_clr", 32'(grant), 32'h0);
        check("abort_valid_clr", 32'(bit_valid), 32'h0);
        @(negedge clk);
        if (stream_done != 4'b0) dcnt++;
        check("abort_next_grant", 32'(grant), 32'b1000);
        check("abort_bits_le10", 32'(vcnt <= 10), 32'd1);
        check("abort_no_done", 32'(dcnt), 32'd0);
        req = 4'b0;
        repeat (4) @(negedge clk);

        // Async reset at cnt=100, then the same stream must repeat exactly.
        bin_in[7:0] = 8'h5A;
        req = 4'b0001;
        wait_grant(t);
        check("rst_run_grant", 32'(grant), 32'b0001);
        n1 = 0;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            if (bit_valid && n1 < 100) begin
                cap1[n1] = bit_out;
                n1++;
            end
        end
        #2 rst_n = 1'b0;
        #1 check_reset_values("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        wait_grant(t);
        check("rerun_grant", 32'(grant), 32'b0001);
        n2 = 0;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            if (bit_valid && n2 < 100) begin
                cap2[n2] = bit_out;
                n2++;
            end
        end
        check("rst_bits_before", 32'(n1), 32'd100);
        check("rst_bits_after", 32'(n2), 32'd100);
        diff = 0;
        for (int i = 0; i < 100; i++) begin
            if (cap1[i] !== cap2[i]) diff++;
        end
        check("rst_sequence_diff", 32'(diff), 32'd0);
        req = 4'b0;
        repeat (4) @(negedge clk);

        // Operand changes after grant are ignored: 64 gives 63 ones.
        run_one(1, 8'd64, 63, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
